// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel fetch path.
package sprite_pkg;

  typedef logic [23:0] rgb_t;
  typedef logic [9:0]  coord_t;

  localparam rgb_t KEY_COLOR = 24'hFF00FF;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   flip;
  } shadow_t;

endpackage

// File: rtl/sprite_anim_ctr.sv
// Run-cycle frame selector: steps 0->1->2->0 every ANIM_DIV frame_start pulses while animating.
// Updates only on frame_start; no backpressure.
module sprite_anim_ctr #(
  parameter int ANIM_DIV = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       animate,
  output logic [1:0] anim_frame
);

  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [DW-1:0] div_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt    <= '0;
      anim_frame <= 2'd0;
    end else if (frame_start) begin
      if (!animate) begin
        div_cnt    <= '0;
        anim_frame <= 2'd0;
      end else if (div_cnt == DW'(ANIM_DIV - 1)) begin
        div_cnt    <= '0;
        anim_frame <= (anim_frame == 2'd2) ? 2'd0 : anim_frame + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite hit test and RAM address generation; result 2 cycles after pix_valid sample.
// Fully pipelined, one pixel per cycle, never stalls.
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int ADDR_W   = 8,
  parameter int ANIM_DIV = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  coord_t            SpriteX,
  input  coord_t            SpriteY,
  input  logic              flip,
  input  logic              animate,
  output logic [ADDR_W-1:0] read_address,
  output logic [1:0]        anim_frame,
  input  rgb_t              ram_data,
  output logic              out_valid,
  output logic              out_hit,
  output rgb_t              out_rgb
);

  shadow_t shadow;

  // Position/facing are frozen per frame so a sprite never tears mid-frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow <= '0;
    end else if (frame_start) begin
      shadow <= '{x: SpriteX, y: SpriteY, flip: flip};
    end
  end

  logic [10:0]       x_ext, y_ext, sx_ext, sy_ext;
  logic              in_box;
  coord_t            dx, dy, col;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    x_ext  = {1'b0, DrawX};
    y_ext  = {1'b0, DrawY};
    sx_ext = {1'b0, shadow.x};
    sy_ext = {1'b0, shadow.y};
    // 11-bit compares so a sprite near column 1023 does not wrap onto column 0.
    in_box = (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPR_W)) &&
             (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPR_H));
    dx     = DrawX - shadow.x;
    dy     = DrawY - shadow.y;
    col    = shadow.flip ? (coord_t'(SPR_W - 1) - dx) : dx;
    addr   = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
  end

  logic vld1, box1, vld2, box2;
  logic hit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      vld1         <= 1'b0;
      box1         <= 1'b0;
      vld2         <= 1'b0;
      box2         <= 1'b0;
    end else begin
      read_address <= (pix_valid && in_box) ? addr : '0;
      vld1         <= pix_valid;
      box1         <= pix_valid && in_box;
      vld2         <= vld1;
      box2         <= box1;
    end
  end

  assign hit = box2 && (ram_data != KEY_COLOR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_rgb   <= '0;
    end else begin
      out_valid <= vld2;
      out_hit   <= hit;
      out_rgb   <= hit ? ram_data : '0;
    end
  end

  sprite_anim_ctr #(
    .ANIM_DIV(ANIM_DIV)
  ) u_anim (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .animate    (animate),
    .anim_frame (anim_frame)
  );

endmodule

// File: doc/sprite_pixel_fetch.md
SPRITE_PIXEL_FETCH -- requirements
Module: sprite_pixel_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 16, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 16, sprite height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 8, sprite RAM address width (ceil(log2(SPR_W*SPR_H))).
REQ-004 SHALL have parameter ANIM_DIV, default 6, frames per animation step (>=1).
REQ-005 SHALL have the following ports:
- Clk  in  1  sole clock; one clock domain; reset is synchronous and active-high.
- Reset  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at start of each video frame.
- pix_valid  in  1  DrawX/DrawY valid this cycle.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- SpriteX  in  10  sprite top-left column (live).
- SpriteY  in  10  sprite top-left row (live).
- flip  in  1  1 = mirror horizontally (facing left).
- animate  in  1  1 = cycle run frames.
- read_address  out  ADDR_W  address to sprite RAM read port.
- anim_frame  out  2  selected run-frame RAM (0,1,2).
- ram_data  in  24  RAM data_Out (registered, 1-cycle read latency).
- out_valid  out  1  pixel result valid.
- out_hit  out  1  opaque sprite pixel at this position.
- out_rgb  out  24  pixel colour; 0 when out_hit=0.

Function
REQ-006 SHALL latch SpriteX, SpriteY, flip into shadow registers only on cycles with frame_start=1; all address math SHALL use shadow values.
REQ-007 SHALL flag in_box when SX<=DrawX<SX+SPR_W and SY<=DrawY<SY+SPR_H, with 11-bit unsigned compares (no wrap at 1023).
REQ-008 SHALL compute col=DrawX-SX, or SPR_W-1-(DrawX-SX) when shadow flip=1; row=DrawY-SY; address=row*SPR_W+col truncated to ADDR_W.
REQ-009 SHALL register read_address at the edge sampling pix_valid; it SHALL drive 0 when pix_valid=0 or in_box=0.
REQ-010 SHALL pipeline pix_valid and in_box two stages to align with ram_data (RAM output valid one edge after read_address).
REQ-011 SHALL produce out_valid/out_hit/out_rgb registered, exactly 2 cycles after the pix_valid sample; throughput one pixel per cycle, no stalls.
REQ-012 SHALL set out_hit=1 only when aligned in_box=1 and ram_data != KEY_COLOR (24'hFF00FF); out_rgb=ram_data when out_hit else 24'h000000.
REQ-013 SHALL, on frame_start with animate=1, increment a divider; at ANIM_DIV-1 the divider SHALL wrap to 0 and anim_frame SHALL step 0->1->2->0.
REQ-014 SHALL, on frame_start with animate=0, clear divider and anim_frame to 0; without frame_start both SHALL hold.
REQ-015 SHALL, when frame_start and pix_valid coincide, use pre-update shadow values for that pixel.
REQ-016 anim_frame SHALL change only at frame boundaries; in-flight pixels complete with the RAM selection current when issued (downstream mux is registered by consumer).

Reset
REQ-017 SHALL, on Reset=1 at an edge, clear: read_address=0, anim_frame=0, divider=0, shadow regs=0, all pipeline valid bits=0, out_valid=0, out_hit=0, out_rgb=0.
REQ-018 SHALL discard in-flight pixels on reset mid-stream; first out_valid=1 no earlier than 2 cycles after first pix_valid after Reset deasserts.

Structure
REQ-019 SHALL place KEY_COLOR, rgb_t (24-bit), coord_t (10-bit) in shared package sprite_pkg.
REQ-020 SHALL implement animation divider/frame stepping in one sub-module, sprite_anim_ctr; rest inline.

Verification
REQ-021 Shadow SpriteX=100,SpriteY=50, flip=0; DrawX=103,DrawY=52 -> read_address=35 next cycle; out_valid 2 cycles after input.
REQ-022 Same with flip=1 -> read_address=44 (row 2, col 12).
REQ-023 RAM word = FF00FF at hit position -> out_hit=0, out_rgb=0, out_valid=1; word=E09050 -> out_hit=1, out_rgb=E09050.
REQ-024 SpriteX=1015, DrawX=5 -> in_box=0, read_address=0, out_hit=0 (no wrap).
REQ-025 animate=1, ANIM_DIV=6, 18 frame_start pulses -> anim_frame 0,1,2,0 changing every 6th pulse; animate=0 then frame_start -> anim_frame=0.
REQ-026 Reset asserted with 2 pixels in flight -> next cycle out_valid=0, all outputs 0; SpriteX change without frame_start ignored until next frame_start.
